min_width_reset_mc: RTL
=======================

MIN_WIDTH_RESET_MC -- requirements
Module: min_width_reset_mc

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent reset channels, range 1-32.
REQ-002 Parameter MIN_WIDTH, default 4: consecutive samples at a new level required before an output changes, range 2-256.
REQ-003 Parameter HOLD_CYCLES, default 8: minimum extra cycles the output stays asserted after assertion, range 0-65535; 0 disables the hold.
REQ-004 Parameter RST_POL, default 0: active level of ch_rst_i and ch_rst_o.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_i  in  1  block reset; synchronous, active-high.
REQ-007 ch_rst_i  in  NUM_CH  per-channel synchronous reset requests to be width-qualified.
REQ-008 ch_rst_o  out  NUM_CH  per-channel qualified resets; registered; polarity RST_POL.
REQ-009 any_rst_o  out  1  registered; 1 when any channel's ch_rst_o was active on the previous cycle; active-high regardless of RST_POL.
REQ-010 clr_i  in  1  clears glitch counters; present only with the macro in REQ-027.
REQ-011 glitch_cnt_o  out  8*NUM_CH  per-channel rejected-pulse counts; channel n occupies bits [8n+7:8n]; present only with the macro in REQ-027.

Function
REQ-012 Each channel shall register ch_rst_i[n] once into sample s; "active" means s == RST_POL; all further logic shall use s only.
REQ-013 Each channel shall run an independent FSM with states DEASSERTED, ARMING, HOLD, ASSERTED, RELEASING, a width counter cnt (8 bits) and a hold counter h (16 bits).
REQ-014 DEASSERTED: s active -> ARMING with cnt=1; otherwise stay.
REQ-015 ARMING: s active and cnt==MIN_WIDTH-1 -> HOLD with h=0 (or ASSERTED if HOLD_CYCLES==0); s active otherwise -> cnt+1; s inactive -> DEASSERTED with cnt=0, counted as a glitch.
REQ-016 HOLD: h==HOLD_CYCLES-1 -> ASSERTED; otherwise h+1; s is ignored in HOLD.
REQ-017 ASSERTED: s inactive -> RELEASING with cnt=1; otherwise stay.
REQ-018 RELEASING: s inactive and cnt==MIN_WIDTH-1 -> DEASSERTED; s inactive otherwise -> cnt+1; s active -> ASSERTED with cnt=0, not counted as a glitch.
REQ-019 ch_rst_o[n] shall be RST_POL in HOLD, ASSERTED and RELEASING, and ~RST_POL in DEASSERTED and ARMING; it shall update on the same edge as the state.
REQ-020 Latency: if ch_rst_i is active before edge 1, ch_rst_o shall assert after edge MIN_WIDTH+1. Pulses of MIN_WIDTH-1 cycles or fewer shall be rejected; pulses of MIN_WIDTH cycles shall be accepted.
REQ-021 Minimum assertion width shall be HOLD_CYCLES+MIN_WIDTH cycles. Deassertion latency from a settled ASSERTED state shall be MIN_WIDTH+1 edges.
REQ-022 Channels shall not interact; simultaneous events on different channels shall be processed independently in the same cycle.

Reset
REQ-023 While rst_i=1: every s = RST_POL, every FSM = ASSERTED, cnt=h=0, ch_rst_o = all RST_POL, any_rst_o=1, glitch counters=0.
REQ-024 rst_i shall override all other inputs, including mid-ARMING, mid-HOLD and mid-RELEASING; outputs shall take reset values after the first edge with rst_i=1.
REQ-025 After rst_i falls with ch_rst_i inactive, ch_rst_o shall deassert after edge MIN_WIDTH+1 and any_rst_o after edge MIN_WIDTH+2.

Configuration
REQ-026 Macro MIN_WIDTH_RESET_GLITCH_CNT_EN defined: each channel shall have an 8-bit counter that increments on each REQ-015 glitch and saturates at 255; clr_i=1 shall zero all counters on the next edge; clear shall win over a same-cycle increment.
REQ-027 Macro not defined: clr_i, glitch_cnt_o and the counters shall be absent; all other behaviour shall be identical.

Verification
(NUM_CH=2, MIN_WIDTH=4, HOLD_CYCLES=8, RST_POL=1, macro defined)
REQ-028 rst_i released, ch_rst_i=0 -> ch_rst_o=11 until edge 5 then 00; any_rst_o falls after edge 6.
REQ-029 3-cycle pulse on ch0 -> ch_rst_o[0] stays 0; glitch_cnt_o[7:0]=1; ch1 unaffected.
REQ-030 4-cycle pulse on ch0 -> ch_rst_o[0]=1 after edge 5, remains 1 for exactly 12 cycles, deasserts after edge 17.
REQ-031 ch0 settled asserted, ch_rst_i[0] dropped for 3 cycles -> ch_rst_o[0] stays 1; glitch count unchanged.
REQ-032 rst_i pulsed during ch1 ARMING -> ch_rst_o=11 after that edge; counters=0; release per REQ-028.
REQ-033 300 rejected pulses on ch0 -> count=255; clr_i asserted on a glitch cycle -> count=0.

Source files
------------

// File: rtl/min_width_reset_mc.sv
// -----------------------------------------------------------------------------
// min_width_reset_mc
//
// Per-channel reset qualifier. Every channel registers its reset request once.
// The qualified output changes only after the new level has been seen for
// MIN_WIDTH consecutive samples. After an assertion the output is held for
// HOLD_CYCLES extra cycles, and the input is ignored during that hold.
//
// Parameters
//   NUM_CH      : number of independent channels (1..32)
//   MIN_WIDTH   : consecutive samples needed before the output changes (2..256)
//   HOLD_CYCLES : extra cycles the output is held after assertion (0 = no hold)
//   RST_POL     : active level of ch_rst_i / ch_rst_o
//
// Ports
//   clk          in   rising-edge clock
//   rst_i        in   block reset, synchronous, active-high
//   clr_i        in   clears the glitch counters (optional feature only)
//   glitch_cnt_o out  8 bits per channel, saturating rejected-pulse counts
//                     (optional feature only)
//   ch_rst_i     in   per-channel raw reset requests
//   ch_rst_o     out  per-channel qualified resets, registered, polarity RST_POL
//   any_rst_o    out  registered, active-high: some ch_rst_o was active on
//                     the previous cycle
//
// Optional feature: define MIN_WIDTH_RESET_GLITCH_CNT_EN to add clr_i,
// glitch_cnt_o and the per-channel glitch counters.
// -----------------------------------------------------------------------------
module min_width_reset_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MIN_WIDTH   = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter bit          RST_POL     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_i,
`ifdef MIN_WIDTH_RESET_GLITCH_CNT_EN
  input  logic                  clr_i,
  output logic [8*NUM_CH-1:0]   glitch_cnt_o,
`endif
  input  logic [NUM_CH-1:0]     ch_rst_i,
  output logic [NUM_CH-1:0]     ch_rst_o,
  output logic                  any_rst_o
);

  typedef enum logic [2:0] {
    ST_DEASSERTED,
    ST_ARMING,
    ST_HOLD,
    ST_ASSERTED,
    ST_RELEASING
  } state_t;

  // Terminal values for the width and hold counters. When HOLD_CYCLES is 0 the
  // HOLD state cannot be reached, so the value of HOLD_LAST does not matter.
  localparam logic [7:0]  CNT_LAST  = 8'(MIN_WIDTH - 1);
  localparam logic [15:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 16'd0 : 16'(HOLD_CYCLES - 1);
  localparam logic        INACTIVE  = !RST_POL;

  logic [NUM_CH-1:0] r_s;       // single-registered input sample
  logic [NUM_CH-1:0] r_out;     // qualified output, polarity RST_POL
  logic              r_any;
  state_t            r_state [NUM_CH];
  logic [7:0]        r_cnt   [NUM_CH];
  logic [15:0]       r_h     [NUM_CH];

  // Sample-is-active per channel, independent of polarity.
  logic [NUM_CH-1:0] w_act;
  assign w_act = ~(r_s ^ {NUM_CH{RST_POL}});

  // NOTE: all state is updated with non-blocking assignments so that every
  // channel (and r_any) sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_s   <= {NUM_CH{RST_POL}};
      r_out <= {NUM_CH{RST_POL}};
      r_any <= 1'b1;
      for (int n = 0; n < NUM_CH; n++) begin
        r_state[n] <= ST_ASSERTED;
        r_cnt[n]   <= '0;
        r_h[n]     <= '0;
      end
    end else begin
      r_s   <= ch_rst_i;
      // Reflects the outputs as they were before this edge.
      r_any <= |(~(r_out ^ {NUM_CH{RST_POL}}));
      for (int n = 0; n < NUM_CH; n++) begin
        unique case (r_state[n])
          ST_DEASSERTED: begin
            if (w_act[n]) begin
              r_state[n] <= ST_ARMING;
              r_cnt[n]   <= 8'd1;
            end
          end
          ST_ARMING: begin
            if (w_act[n]) begin
              if (r_cnt[n] == CNT_LAST) begin
                r_state[n] <= (HOLD_CYCLES == 0) ? ST_ASSERTED : ST_HOLD;
                r_cnt[n]   <= '0;
                r_h[n]     <= '0;
                r_out[n]   <= RST_POL;
              end else begin
                r_cnt[n] <= r_cnt[n] + 8'd1;
              end
            end else begin
              // Pulse too short: rejected as a glitch.
              r_state[n] <= ST_DEASSERTED;
              r_cnt[n]   <= '0;
            end
          end
          ST_HOLD: begin
            // The input is deliberately ignored while holding.
            if (r_h[n] == HOLD_LAST) begin
              r_state[n] <= ST_ASSERTED;
            end else begin
              r_h[n] <= r_h[n] + 16'd1;
            end
          end
          ST_ASSERTED: begin
            if (!w_act[n]) begin
              r_state[n] <= ST_RELEASING;
              r_cnt[n]   <= 8'd1;
            end
          end
          ST_RELEASING: begin
            if (!w_act[n]) begin
              if (r_cnt[n] == CNT_LAST) begin
                r_state[n] <= ST_DEASSERTED;
                r_cnt[n]   <= '0;
                r_out[n]   <= INACTIVE;
              end else begin
                r_cnt[n] <= r_cnt[n] + 8'd1;
              end
            end else begin
              // A short drop while asserted is absorbed, not a glitch.
              r_state[n] <= ST_ASSERTED;
              r_cnt[n]   <= '0;
            end
          end
          default: begin
            r_state[n] <= ST_ASSERTED;
            r_cnt[n]   <= '0;
            r_h[n]     <= '0;
            r_out[n]   <= RST_POL;
          end
        endcase
      end
    end
  end

  assign ch_rst_o  = r_out;
  assign any_rst_o = r_any;

`ifdef MIN_WIDTH_RESET_GLITCH_CNT_EN
  logic [7:0] r_gcnt [NUM_CH];

  // Clear has priority over a same-cycle increment. Counts saturate at 255.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_CH; n++) begin
      if (rst_i || clr_i) begin
        r_gcnt[n] <= '0;
      end else if ((r_state[n] == ST_ARMING) && !w_act[n] && (r_gcnt[n] != 8'hFF)) begin
        r_gcnt[n] <= r_gcnt[n] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_gcnt
    assign glitch_cnt_o[8*g +: 8] = r_gcnt[g];
  end
`endif

endmodule
